// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage with valid/ready handshake and a two-entry skid buffer.
// Outputs come straight from the main entry registers; invalid entries carry the bubble encoding.
module ex_mem_skid_stage #(
    parameter int          XLEN        = 32,
    parameter int          CTRL_W      = 5,
    parameter logic [4:0]  NOP_RD_ADDR = 5'b00000,
    parameter int          CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [4:0]        in_rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_alu_result,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [4:0]        out_rd_addr,
    output logic [1:0]        count,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [XLEN-1:0]   r_main_alu;
    logic [XLEN-1:0]   r_main_rs2;
    logic [4:0]        r_main_rd;

    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [XLEN-1:0]   r_skid_alu;
    logic [XLEN-1:0]   r_skid_rs2;
    logic [4:0]        r_skid_rd;

    logic              r_in_ready;
    logic [1:0]        r_count;
    logic [CNT_W-1:0]  r_stall;

    logic              w_acc;
    logic              w_fire;
    logic              w_stall_inc;

    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [XLEN-1:0]   w_main_alu;
    logic [XLEN-1:0]   w_main_rs2;
    logic [4:0]        w_main_rd;

    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [XLEN-1:0]   w_skid_alu;
    logic [XLEN-1:0]   w_skid_rs2;
    logic [4:0]        w_skid_rd;

    assign w_acc       = in_valid & r_in_ready;
    assign w_fire      = r_main_valid & out_ready;
    assign w_stall_inc = r_main_valid & ~out_ready & ~(&r_stall);

    always_comb begin
        w_main_valid = r_main_valid;
        w_main_ctrl  = r_main_ctrl;
        w_main_alu   = r_main_alu;
        w_main_rs2   = r_main_rs2;
        w_main_rd    = r_main_rd;
        w_skid_valid = r_skid_valid;
        w_skid_ctrl  = r_skid_ctrl;
        w_skid_alu   = r_skid_alu;
        w_skid_rs2   = r_skid_rs2;
        w_skid_rd    = r_skid_rd;

        if (flush) begin
            // Data fields are left alone; only valid/ctrl/rd define a bubble.
            w_main_valid = 1'b0;
            w_main_ctrl  = '0;
            w_main_rd    = NOP_RD_ADDR;
            w_skid_valid = 1'b0;
            w_skid_ctrl  = '0;
            w_skid_rd    = NOP_RD_ADDR;
        end else if (!r_main_valid) begin
            if (w_acc) begin
                w_main_valid = 1'b1;
                w_main_ctrl  = in_ctrl;
                w_main_alu   = in_alu_result;
                w_main_rs2   = in_rs2_data;
                w_main_rd    = in_rd_addr;
            end else begin
                w_main_ctrl  = '0;
                w_main_rd    = NOP_RD_ADDR;
            end
        end else if (!r_skid_valid) begin
            if (w_fire) begin
                if (w_acc) begin
                    w_main_ctrl = in_ctrl;
                    w_main_alu  = in_alu_result;
                    w_main_rs2  = in_rs2_data;
                    w_main_rd   = in_rd_addr;
                end else begin
                    w_main_valid = 1'b0;
                    w_main_ctrl  = '0;
                    w_main_rd    = NOP_RD_ADDR;
                end
            end else if (w_acc) begin
                w_skid_valid = 1'b1;
                w_skid_ctrl  = in_ctrl;
                w_skid_alu   = in_alu_result;
                w_skid_rs2   = in_rs2_data;
                w_skid_rd    = in_rd_addr;
            end
        end else if (w_fire) begin
            // in_ready is low while the skid is full, so no accept competes here.
            w_main_ctrl  = r_skid_ctrl;
            w_main_alu   = r_skid_alu;
            w_main_rs2   = r_skid_rs2;
            w_main_rd    = r_skid_rd;
            w_skid_valid = 1'b0;
            w_skid_ctrl  = '0;
            w_skid_rd    = NOP_RD_ADDR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_alu   <= '0;
            r_main_rs2   <= '0;
            r_main_rd    <= NOP_RD_ADDR;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_alu   <= '0;
            r_skid_rs2   <= '0;
            r_skid_rd    <= NOP_RD_ADDR;
            r_in_ready   <= 1'b1;
            r_count      <= 2'd0;
            r_stall      <= '0;
        end else begin
            r_main_valid <= w_main_valid;
            r_main_ctrl  <= w_main_ctrl;
            r_main_alu   <= w_main_alu;
            r_main_rs2   <= w_main_rs2;
            r_main_rd    <= w_main_rd;
            r_skid_valid <= w_skid_valid;
            r_skid_ctrl  <= w_skid_ctrl;
            r_skid_alu   <= w_skid_alu;
            r_skid_rs2   <= w_skid_rs2;
            r_skid_rd    <= w_skid_rd;
            r_in_ready   <= ~w_skid_valid;
            r_count      <= {1'b0, w_main_valid} + {1'b0, w_skid_valid};
            if (w_stall_inc) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = r_main_valid;
    assign out_ctrl       = r_main_ctrl;
    assign out_alu_result = r_main_alu;
    assign out_rs2_data   = r_main_rs2;
    assign out_rd_addr    = r_main_rd;
    assign count          = r_count;
    assign stall_cycles   = r_stall;

endmodule

// File: doc/ex_mem_skid_stage.md
# ex_mem_skid_stage

Parametrised EX→MEM pipeline stage with a valid/ready handshake and a two-entry skid buffer. It replaces the plain always-load stage register between Execute and Memory. It can absorb one beat of downstream backpressure without a combinational ready path, supports a synchronous flush that turns every held entry into a bubble, and keeps a saturating count of stall cycles for performance analysis.

## Interface
Parameters:
- XLEN, 32, width of the ALU result and store-data fields.
- CTRL_W, 5, control-bit vector width ({regwrite, memtoreg, memread, memwrite, branch}, MSB first); all-zero is a NOP.
- NOP_RD_ADDR, 5'b00000, rd value presented when no valid entry is at the output.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  EX presents a beat.
- in_ready  out  1  stage can accept a beat; registered.
- in_ctrl  in  CTRL_W  control bits from EX.
- in_alu_result  in  XLEN  ALU result.
- in_rs2_data  in  XLEN  store data.
- in_rd_addr  in  5  destination register.
- out_valid  out  1  beat available to MEM.
- out_ready  in  1  MEM accepts the beat.
- out_ctrl  out  CTRL_W  control bits; all zero whenever out_valid=0.
- out_alu_result  out  XLEN  ALU result.
- out_rs2_data  out  XLEN  store data.
- out_rd_addr  out  5  destination register; NOP_RD_ADDR whenever out_valid=0.
- count  out  2  entries held (0..2).
- stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: a main entry, which drives the outputs, and a skid entry. Each entry holds valid, ctrl, alu_result, rs2_data and rd_addr.
- Accept: `acc = in_valid & in_ready`. Output fire: `fire = out_valid & out_ready`.
- `in_ready` = skid empty, registered.
- `count` = main_valid + skid_valid, registered.
- Order is strictly FIFO; no beat is duplicated or dropped except by flush.
- Next-state rules when flush=0:
  - Main empty, acc: main ← input.
  - Main full, fire, skid empty, acc: main ← input.
  - Main full, fire, skid empty, no acc: main becomes invalid (bubble).
  - Main full, no fire, skid empty, acc: skid ← input; in_ready falls next cycle.
  - Main full, fire, skid full: main ← skid, skid becomes empty, in_ready rises next cycle. No acc is possible because in_ready=0.
  - Main full, no fire, skid full: hold everything.
- Bubble encoding: whenever an entry becomes or stays invalid, its stored ctrl is written to 0 and its rd to NOP_RD_ADDR. The outputs are therefore registered values with no output mux.
- Data fields of an invalid main entry hold their last value; they are don't-care but stable.
- Flush (priority over everything except rst):
  - Next edge clears both entries to the bubble encoding.
  - count becomes 0 and in_ready becomes 1.
  - A beat accepted in the flush cycle is discarded.
  - fire in the flush cycle still counts as delivered to MEM.
- stall_cycles:
  - Increments on each edge where out_valid=1 and out_ready=0.
  - Saturates at all-ones.
  - Not cleared by flush; cleared only by rst.

## Timing
- Reset values (while rst=1, asynchronously): out_valid=0, out_ctrl=0, out_alu_result=0, out_rs2_data=0, out_rd_addr=NOP_RD_ADDR, skid cleared, in_ready=1, count=0, stall_cycles=0.
- Latency: a beat accepted at edge N appears on out_* after edge N when the main entry is empty or firing.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure:
  - One stall cycle fills the skid; in_ready deasserts one cycle after out_ready drops.
  - No combinational path from out_ready to in_ready.
- Rst deasserted mid-stream: the first accept is possible on the first edge after release.

## Test plan
- Reset/idle: assert rst mid-stream with count=2 → out_valid=0, out_ctrl=0, out_rd_addr=0, in_ready=1, count=0, stall_cycles=0 immediately (asynchronously).
- Streaming: in_valid=1, out_ready=1, rd=1..8, alu_result=0x100+i → out sees rd 1..8 in order, one per cycle, with 1-cycle latency and count≤1.
- Backpressure:
  - Setup: stream rd=1,2,3 and drop out_ready for 3 cycles starting when rd=1 is at the output.
  - Occupancy: rd=2 goes to skid, count=2, in_ready=0 from the next cycle, rd=3 is held at the EX side.
  - Counter: stall_cycles=3.
  - Release: on re-assert, out sees 1,2,3 with no loss.
- Flush with count=2 and in_valid=1 in the same cycle → next cycle out_valid=0, out_ctrl=0, count=0, in_ready=1, and the input beat is not delivered.
- Bubble encoding: accept ctrl=5'b11111, rd=7, fire it, supply no new input → out_ctrl=0, out_rd_addr=NOP_RD_ADDR next cycle.
- Saturation with CNT_W=3: hold out_valid=1, out_ready=0 for 10 cycles → stall_cycles stops at 7.
